// File: rtl/test_sig_monitor.sv
// ---------------------------------------------------------------------------
// test_sig_monitor
//
// Watches CPU writes during a self-test and reaches a verdict: a write to
// SIG_ADDR carrying SIG_EXPECT is a pass, any other value written there is a
// fail, and reaching TIMEOUT ph1 cycles with no signature write is a timeout.
// Verdicts are terminal until reset.
//
// Optional feature (macro TEST_SIG_MONITOR_SIGLOG_EN): an 8-entry write log
// FIFO recording {address, dataout} of every write seen while running.
//
// Ports
//   ph1        in   1   clock, all state changes on its rising edge
//   reset      in   1   asynchronous, active-high reset
//   address    in  16   CPU bus address
//   dataout    in   8   CPU write data
//   memwrite   in   1   CPU write strobe
//   log_pop    in   1   pop oldest log entry            (SIGLOG_EN only)
//   log_data   out 24   {address, dataout} of the head  (SIGLOG_EN only)
//   log_empty  out  1   log holds no entries            (SIGLOG_EN only)
//   log_ovf    out  1   sticky: a log entry was dropped (SIGLOG_EN only)
//   done       out  1   a verdict has been reached
//   pass       out  1   signature matched SIG_EXPECT
//   fail       out  1   signature mismatched
//   timeout    out  1   TIMEOUT reached with no signature write
//   cycles     out 16   ph1 cycles spent in RUN
//   wr_count   out  8   CPU writes seen in RUN, saturating at 8'hFF
//   sig_data   out  8   value captured from the signature write
//   state_dbg  out  2   FSM state: 0=RUN 1=PASS 2=FAIL 3=TOUT
//
// Bus handshake: this block is a pure write responder. A write is one ph1
// edge with memwrite=1; there is no ready/backpressure, every sampled write
// is accepted. The log pop side is a valid/ready pair where log_empty=0 is
// "valid" and log_pop is "ready": an entry is consumed on an edge where both
// hold; log_pop while empty does nothing.
// ---------------------------------------------------------------------------
module test_sig_monitor #(
  parameter logic [15:0] SIG_ADDR   = 16'h0030,
  parameter logic [7:0]  SIG_EXPECT = 8'hCE,
  parameter logic [15:0] TIMEOUT    = 16'd195
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  dataout,
  input  logic        memwrite,
`ifdef TEST_SIG_MONITOR_SIGLOG_EN
  input  logic        log_pop,
  output logic [23:0] log_data,
  output logic        log_empty,
  output logic        log_ovf,
`endif
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] cycles,
  output logic [7:0]  wr_count,
  output logic [7:0]  sig_data,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  state_t state;
  logic   sig_hit;
  logic   tout_hit;

  assign state_dbg = state;

  always_comb begin
    sig_hit  = memwrite && (address == SIG_ADDR);
    tout_hit = (cycles == (TIMEOUT - 16'd1));
  end

  // Verdict flags are set on the same edge as the state change so they are
  // plain registers with no path from the bus inputs.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      cycles   <= 16'd0;
      wr_count <= 8'd0;
      sig_data <= 8'd0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
    end else if (state == ST_RUN) begin
      cycles <= cycles + 16'd1;
      if (memwrite && (wr_count != 8'hFF)) begin
        wr_count <= wr_count + 8'd1;
      end
      // A signature write beats a coincident timeout.
      if (sig_hit) begin
        sig_data <= dataout;
        done     <= 1'b1;
        if (dataout == SIG_EXPECT) begin
          state <= ST_PASS;
          pass  <= 1'b1;
        end else begin
          state <= ST_FAIL;
          fail  <= 1'b1;
        end
      end else if (tout_hit) begin
        state   <= ST_TOUT;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

`ifdef TEST_SIG_MONITOR_SIGLOG_EN
  logic [23:0] log_mem [8];
  logic [2:0]  log_wp;
  logic [2:0]  log_rp;
  logic [3:0]  log_cnt;
  logic        log_full;
  logic        log_push;
  logic        log_push_ok;
  logic        log_pop_ok;

  // When full, a push is accepted only if a pop frees the head slot on the
  // same edge; the new entry lands in that freed slot (wp == rp when full).
  always_comb begin
    log_full    = (log_cnt == 4'd8);
    log_pop_ok  = log_pop && (log_cnt != 4'd0);
    log_push    = memwrite && (state == ST_RUN);
    log_push_ok = log_push && (!log_full || log_pop_ok);
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      log_wp  <= 3'd0;
      log_rp  <= 3'd0;
      log_cnt <= 4'd0;
      log_ovf <= 1'b0;
    end else begin
      if (log_push_ok) begin
        log_wp <= log_wp + 3'd1;
      end
      if (log_pop_ok) begin
        log_rp <= log_rp + 3'd1;
      end
      if (log_push_ok && !log_pop_ok) begin
        log_cnt <= log_cnt + 4'd1;
      end else if (!log_push_ok && log_pop_ok) begin
        log_cnt <= log_cnt - 4'd1;
      end
      if (log_push && !log_push_ok) begin
        log_ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: log_data is masked to 0 while the log is empty.
  always_ff @(posedge ph1) begin
    if (log_push_ok) begin
      log_mem[log_wp] <= {address, dataout};
    end
  end

  assign log_empty = (log_cnt == 4'd0);
  assign log_data  = (log_cnt != 4'd0) ? log_mem[log_rp] : 24'd0;
`endif

endmodule

// File: tb/tb_test_sig_monitor.sv
// ---------------------------------------------------------------------------
// tb_test_sig_monitor
//
// Two monitors share one bus: dut_a with the default TIMEOUT (195) and dut_b
// with TIMEOUT=1000 so long write bursts can reach wr_count saturation before
// any timeout. Each scenario is a table of per-edge writes; the reference
// model derives the verdict from the table (first signature write vs. the
// timeout edge) and pushes it into a per-DUT expected queue. A monitor pops
// and compares whenever done rises.
// ---------------------------------------------------------------------------
module tb_test_sig_monitor;

  localparam logic [15:0] SIG_ADDR   = 16'h0030;
  localparam logic [7:0]  SIG_EXPECT = 8'hCE;
  localparam int          T_SHORT    = 195;
  localparam int          T_LONG     = 1000;
  localparam int          MAX_N      = 400;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        tout;
    logic [15:0] cycles;
    logic [7:0]  wr_count;
    logic [7:0]  sig_data;
    logic [1:0]  st;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  // ---------------- clock / reset ----------------
  logic        ph1 = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  dataout;
  logic        memwrite;

  always #5 ph1 = ~ph1;

  logic        a_done, a_pass, a_fail, a_timeout;
  logic [15:0] a_cycles;
  logic [7:0]  a_wr_count, a_sig_data;
  logic [1:0]  a_state;
  logic        b_done, b_pass, b_fail, b_timeout;
  logic [15:0] b_cycles;
  logic [7:0]  b_wr_count, b_sig_data;
  logic [1:0]  b_state;
`ifdef TEST_SIG_MONITOR_SIGLOG_EN
  logic        log_pop;
  logic [23:0] a_log_data, b_log_data;
  logic        a_log_empty, b_log_empty, a_log_ovf, b_log_ovf;
`endif

  test_sig_monitor #(.SIG_ADDR(SIG_ADDR), .SIG_EXPECT(SIG_EXPECT), .TIMEOUT(16'(T_SHORT))) dut_a (
    .ph1(ph1), .reset(reset), .address(address), .dataout(dataout), .memwrite(memwrite),
`ifdef TEST_SIG_MONITOR_SIGLOG_EN
    .log_pop(log_pop), .log_data(a_log_data), .log_empty(a_log_empty), .log_ovf(a_log_ovf),
`endif
    .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
    .cycles(a_cycles), .wr_count(a_wr_count), .sig_data(a_sig_data), .state_dbg(a_state)
  );

  test_sig_monitor #(.SIG_ADDR(SIG_ADDR), .SIG_EXPECT(SIG_EXPECT), .TIMEOUT(16'(T_LONG))) dut_b (
    .ph1(ph1), .reset(reset), .address(address), .dataout(dataout), .memwrite(memwrite),
`ifdef TEST_SIG_MONITOR_SIGLOG_EN
    .log_pop(log_pop), .log_data(b_log_data), .log_empty(b_log_empty), .log_ovf(b_log_ovf),
`endif
    .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
    .cycles(b_cycles), .wr_count(b_wr_count), .sig_data(b_sig_data), .state_dbg(b_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_a_q[$];
  logic [REC_W-1:0] exp_b_q[$];

  logic        wr_en   [1:MAX_N];
  logic [15:0] wr_addr [1:MAX_N];
  logic [7:0]  wr_data [1:MAX_N];
  int          n_edges;

  function automatic rec_t rec_a();
    rec_t r;
    r.done = a_done; r.pass = a_pass; r.fail = a_fail; r.tout = a_timeout;
    r.cycles = a_cycles; r.wr_count = a_wr_count; r.sig_data = a_sig_data; r.st = a_state;
    return r;
  endfunction

  function automatic rec_t rec_b();
    rec_t r;
    r.done = b_done; r.pass = b_pass; r.fail = b_fail; r.tout = b_timeout;
    r.cycles = b_cycles; r.wr_count = b_wr_count; r.sig_data = b_sig_data; r.st = b_state;
    return r;
  endfunction

  task automatic check_rec(input string name, input rec_t got, input rec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (fields done,pass,fail,tout,cycles,wr_count,sig_data,st)",
               name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference model: the run ends at the first signature write if it comes
  // no later than edge t, otherwise at edge t as a timeout, otherwise the
  // scenario simply ends still running.
  function automatic rec_t model(input int t);
    rec_t r;
    int   k;
    int   stop;
    int   writes;
    r = '0;
    k = 0;
    writes = 0;
    for (int e = 1; e <= n_edges; e++) begin
      if (k == 0 && wr_en[e] && wr_addr[e] == SIG_ADDR) k = e;
    end
    if (k != 0 && k <= t) begin
      stop = k;
      r.done = 1'b1;
      r.sig_data = wr_data[k];
      if (wr_data[k] == SIG_EXPECT) begin
        r.pass = 1'b1; r.st = 2'd1;
      end else begin
        r.fail = 1'b1; r.st = 2'd2;
      end
    end else if (n_edges >= t) begin
      stop = t;
      r.done = 1'b1; r.tout = 1'b1; r.st = 2'd3;
    end else begin
      stop = n_edges;
    end
    for (int e = 1; e <= stop; e++) begin
      if (wr_en[e]) writes++;
    end
    r.cycles   = 16'(stop);
    r.wr_count = (writes > 255) ? 8'hFF : 8'(writes);
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic a_done_q = 1'b0;
  logic b_done_q = 1'b0;

  always @(negedge ph1) begin
    rec_t e;
    if (a_done && !a_done_q) begin
      if (exp_a_q.size() == 0) begin
        check_val("verdict_a_unexpected", 32'(a_done), 32'd0);
      end else begin
        e = rec_t'(exp_a_q.pop_front());
        check_rec("verdict_a", rec_a(), e);
      end
    end
    if (b_done && !b_done_q) begin
      if (exp_b_q.size() == 0) begin
        check_val("verdict_b_unexpected", 32'(b_done), 32'd0);
      end else begin
        e = rec_t'(exp_b_q.pop_front());
        check_rec("verdict_b", rec_b(), e);
      end
    end
    a_done_q = a_done;
    b_done_q = b_done;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_table(input int n);
    n_edges = n;
    for (int e = 1; e <= MAX_N; e++) begin
      wr_en[e] = 1'b0; wr_addr[e] = 16'h0000; wr_data[e] = 8'h00;
    end
  endtask

  task automatic set_wr(input int e, input logic [15:0] a, input logic [7:0] d);
    wr_en[e] = 1'b1; wr_addr[e] = a; wr_data[e] = d;
  endtask

  task automatic check_reset_values(input string tag);
    check_rec({tag, "_rst_a"}, rec_a(), '0);
    check_rec({tag, "_rst_b"}, rec_b(), '0);
`ifdef TEST_SIG_MONITOR_SIGLOG_EN
    check_val({tag, "_rst_log_a"}, {6'd0, a_log_ovf, a_log_empty, a_log_data}, 32'h0100_0000);
    check_val({tag, "_rst_log_b"}, {6'd0, b_log_ovf, b_log_empty, b_log_data}, 32'h0100_0000);
`endif
  endtask

  // Called at a point between edges; reset takes effect without a clock edge.
  task automatic run_scenario(input string tag);
    rec_t ea;
    rec_t eb;
    reset = 1'b1;
`ifdef TEST_SIG_MONITOR_SIGLOG_EN
    log_pop = 1'b0;
`endif
    #1;
    check_reset_values({tag, "_async"});
    // A signature write while reset is held must be ignored.
    address = SIG_ADDR; dataout = SIG_EXPECT; memwrite = 1'b1;
    @(posedge ph1);
    @(posedge ph1);
    @(negedge ph1);
    check_reset_values({tag, "_held"});
    reset = 1'b0;
    memwrite = 1'b0;
    ea = model(T_SHORT);
    eb = model(T_LONG);
    if (ea.done) exp_a_q.push_back(ea);
    if (eb.done) exp_b_q.push_back(eb);
    for (int e = 1; e <= n_edges; e++) begin
      address = wr_addr[e]; dataout = wr_data[e]; memwrite = wr_en[e];
      @(negedge ph1);
    end
    memwrite = 1'b0;
    #1;
    check_val({tag, "_pending_a"}, 32'(exp_a_q.size()), 32'd0);
    check_val({tag, "_pending_b"}, 32'(exp_b_q.size()), 32'd0);
    exp_a_q.delete();
    exp_b_q.delete();
    check_rec({tag, "_final_a"}, rec_a(), ea);
    check_rec({tag, "_final_b"}, rec_b(), eb);
  endtask

`ifdef TEST_SIG_MONITOR_SIGLOG_EN
  task automatic drain_log(input string tag, input logic [23:0] lq[$]);
    for (int i = 0; i < lq.size(); i++) begin
      check_val({tag, "_head_a"}, {8'd0, a_log_data}, {8'd0, lq[i]});
      check_val({tag, "_head_b"}, {8'd0, b_log_data}, {8'd0, lq[i]});
      log_pop = 1'b1;
      @(negedge ph1);
      log_pop = 1'b0;
    end
    check_val({tag, "_empty_a"}, {7'd0, a_log_empty, a_log_data}, 32'h0100_0000);
    check_val({tag, "_empty_b"}, {7'd0, b_log_empty, b_log_data}, 32'h0100_0000);
  endtask

  task automatic log_tests();
    logic [23:0] lq[$];
    logic [7:0]  d9;
    // Overflow: nine writes, no pops.
    clear_table(9);
    for (int e = 1; e <= 9; e++) set_wr(e, 16'h0100 + 16'(e), 8'($urandom_range(0, 255)));
    run_scenario("log_ovf");
    check_val("log_ovf_a", {30'd0, a_log_ovf, a_log_empty}, 32'd2);
    check_val("log_ovf_b", {30'd0, b_log_ovf, b_log_empty}, 32'd2);
    lq.delete();
    for (int e = 1; e <= 8; e++) lq.push_back({wr_addr[e], wr_data[e]});
    drain_log("log_drain", lq);
    // Pop while empty is ignored; overflow flag stays sticky.
    log_pop = 1'b1;
    @(negedge ph1);
    log_pop = 1'b0;
    check_val("log_pop_empty_a", {30'd0, a_log_ovf, a_log_empty}, 32'd3);
    // Full log with simultaneous push and pop: both take effect.
    clear_table(8);
    for (int e = 1; e <= 8; e++) set_wr(e, 16'h0300 + 16'(e), 8'($urandom_range(0, 255)));
    run_scenario("log_full");
    d9 = 8'($urandom_range(0, 255));
    address = 16'h0309; dataout = d9; memwrite = 1'b1; log_pop = 1'b1;
    @(negedge ph1);
    memwrite = 1'b0; log_pop = 1'b0;
    check_val("log_pushpop_ovf_a", {31'd0, a_log_ovf}, 32'd0);
    check_val("log_pushpop_ovf_b", {31'd0, b_log_ovf}, 32'd0);
    lq.delete();
    for (int e = 2; e <= 8; e++) lq.push_back({wr_addr[e], wr_data[e]});
    lq.push_back({16'h0309, d9});
    drain_log("log_pushpop", lq);
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; address = 16'h0000; dataout = 8'h00; memwrite = 1'b0;
`ifdef TEST_SIG_MONITOR_SIGLOG_EN
    log_pop = 1'b0;
`endif

    // 10 idle edges, then a passing signature write.
    clear_table(14);
    set_wr(11, SIG_ADDR, 8'hCE);
    run_scenario("pass_11");

    // Wrong signature, later correct one is ignored.
    clear_table(12);
    set_wr(4, SIG_ADDR, 8'h5A);
    set_wr(8, SIG_ADDR, 8'hCE);
    run_scenario("fail_5a");

    // No writes: timeout at 195.
    clear_table(197);
    run_scenario("tout");

    // Signature on the timeout edge wins.
    clear_table(197);
    set_wr(195, SIG_ADDR, 8'hCE);
    run_scenario("sig_at_195");

    // Signature one edge too late.
    clear_table(198);
    set_wr(196, SIG_ADDR, 8'hCE);
    run_scenario("sig_at_196");

    // 300 non-signature writes then the signature: saturation on dut_b.
    clear_table(303);
    for (int e = 1; e <= 300; e++) set_wr(e, 16'h0200, 8'($urandom_range(0, 255)));
    set_wr(301, SIG_ADDR, 8'hCE);
    run_scenario("sat_300");

    // Run 50 edges, then reset mid-RUN; the next scenario restarts the count.
    clear_table(50);
    for (int e = 1; e <= 50; e += 3) set_wr(e, 16'h0201, 8'(e));
    run_scenario("mid_run_50");
    clear_table(5);
    run_scenario("restart_5");

    // Randomized scenarios.
    for (int s = 0; s < 8; s++) begin
      clear_table($urandom_range(20, 260));
      for (int e = 1; e <= n_edges; e++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 39) == 0)
            set_wr(e, SIG_ADDR, ($urandom_range(0, 1) == 1) ? SIG_EXPECT : 8'($urandom_range(0, 255)));
          else
            set_wr(e, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)));
        end
      end
      run_scenario($sformatf("rand_%0d", s));
    end

`ifdef TEST_SIG_MONITOR_SIGLOG_EN
    log_tests();
`endif

    reset = 1'b1;
    #1;
    check_reset_values("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
